// File: rtl/iob_ibex2axi_xfer.sv
// ============================================================================
// iob_ibex2axi_xfer : Ibex instr/data port to AXI4-Lite master, one xfer at a time
// Rev 1.0
// ============================================================================
`default_nettype none

module iob_ibex2axi_xfer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic [1:0]          curr_turn_i,
  // Ibex instruction port
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  output logic                instr_err_o,
  // Ibex data port
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]   axi_araddr_o,
  output logic                axi_arvalid_o,
  input  logic                axi_arready_i,
  input  logic [DATA_W-1:0]   axi_rdata_i,
  input  logic [1:0]          axi_rresp_i,
  input  logic                axi_rvalid_i,
  output logic                axi_rready_o,
  output logic [ADDR_W-1:0]   axi_awaddr_o,
  output logic                axi_awvalid_o,
  input  logic                axi_awready_i,
  output logic [DATA_W-1:0]   axi_wdata_o,
  output logic [DATA_W/8-1:0] axi_wstrb_o,
  output logic                axi_wvalid_o,
  input  logic                axi_wready_i,
  input  logic [1:0]          axi_bresp_i,
  input  logic                axi_bvalid_i,
  output logic                axi_bready_o
);

  localparam logic [1:0] TURN_INSTR = 2'b01;
  localparam logic [1:0] TURN_DATA  = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_RESP = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              state;
  logic                src_data;
  logic                aw_done;
  logic                w_done;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;

  logic issue_instr, issue_data;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic aw_fin, w_fin, wr_last;
  logic unused_resp;

  assign issue_instr = cke_i && (curr_turn_i == TURN_INSTR) && instr_req_i;
  assign issue_data  = cke_i && (curr_turn_i == TURN_DATA) && data_req_i;

  assign ar_hs = axi_arvalid_o && axi_arready_i;
  assign r_hs  = axi_rvalid_i && axi_rready_o;
  assign aw_hs = axi_awvalid_o && axi_awready_i;
  assign w_hs  = axi_wvalid_o && axi_wready_i;
  assign b_hs  = axi_bvalid_i && axi_bready_o;

  // A channel counts as finished if it completed earlier or completes now
  assign aw_fin  = aw_done || aw_hs;
  assign w_fin   = w_done || w_hs;
  assign wr_last = (state == WR_REQ) && aw_fin && w_fin;

  assign instr_gnt_o = ar_hs && !src_data;
  assign data_gnt_o  = (ar_hs && src_data) || (wr_last && src_data);

  assign axi_araddr_o = addr_q;
  assign axi_awaddr_o = addr_q;
  assign axi_wdata_o  = wdata_q;
  assign axi_wstrb_o  = be_q;

  assign unused_resp = ^{axi_rresp_i[0], axi_bresp_i[0]};

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state          <= IDLE;
      src_data       <= 1'b0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      axi_arvalid_o  <= 1'b0;
      axi_rready_o   <= 1'b0;
      axi_awvalid_o  <= 1'b0;
      axi_wvalid_o   <= 1'b0;
      axi_bready_o   <= 1'b0;
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= '0;
      instr_err_o    <= 1'b0;
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= '0;
      data_err_o     <= 1'b0;
    end else begin
      instr_rvalid_o <= 1'b0;
      data_rvalid_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_instr) begin
            addr_q        <= instr_addr_i;
            src_data      <= 1'b0;
            axi_arvalid_o <= 1'b1;
            state         <= RD_ADDR;
          end else if (issue_data) begin
            addr_q   <= data_addr_i;
            wdata_q  <= data_wdata_i;
            be_q     <= data_be_i;
            src_data <= 1'b1;
            if (data_we_i) begin
              axi_awvalid_o <= 1'b1;
              axi_wvalid_o  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              axi_arvalid_o <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= 1'b1;
            state         <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            axi_rready_o <= 1'b0;
            if (src_data) begin
              data_rdata_o  <= axi_rdata_i;
              data_err_o    <= axi_rresp_i[1];
              data_rvalid_o <= 1'b1;
            end else begin
              instr_rdata_o  <= axi_rdata_i;
              instr_err_o    <= axi_rresp_i[1];
              instr_rvalid_o <= 1'b1;
            end
            state <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_hs) axi_awvalid_o <= 1'b0;
          if (w_hs)  axi_wvalid_o  <= 1'b0;
          if (aw_fin && w_fin) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            axi_bready_o <= 1'b1;
            state        <= WR_RESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            axi_bready_o  <= 1'b0;
            data_err_o    <= axi_bresp_i[1];
            data_rvalid_o <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/iob_ibex2axi_xfer.md
IOB_IBEX2AXI_XFER -- requirements
Module: iob_ibex2axi_xfer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width on both the Ibex and AXI sides.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width; DATA_W/8 is the strobe width.
REQ-003 The block SHALL use one clock and an asynchronous active-high reset; the ports SHALL be clk_i, cke_i and arst_i, listed first in that order.
REQ-004 The block SHALL have these ports, as name, direction, width, meaning:
- clk_i, in, 1, clock.
- cke_i, in, 1, clock enable; gates new-transaction issue only.
- arst_i, in, 1, async reset, active-high.
- curr_turn_i, in, 2, turn from the upstream arbiter: 00 = NO, 01 = TURN_0 (instruction), 10 = TURN_1 (data), 11 = STALL.
- instr_req_i, in, 1, instruction fetch request.
- instr_addr_i, in, ADDR_W, fetch address.
- instr_gnt_o, out, 1, fetch accepted.
- instr_rvalid_o, out, 1, fetch data valid.
- instr_rdata_o, out, DATA_W, fetch data.
- instr_err_o, out, 1, fetch error.
- data_req_i, in, 1, data request.
- data_we_i, in, 1, write enable.
- data_be_i, in, DATA_W/8, byte enables.
- data_addr_i, in, ADDR_W, data address.
- data_wdata_i, in, DATA_W, write data.
- data_gnt_o, out, 1, data request accepted.
- data_rvalid_o, out, 1, data response valid.
- data_rdata_o, out, DATA_W, read data.
- data_err_o, out, 1, data error.
- AXI4-Lite master: axi_araddr_o/arvalid_o (out), axi_arready_i (in), axi_rdata_i/rresp_i[2]/rvalid_i (in), axi_rready_o (out), axi_awaddr_o/awvalid_o (out), axi_awready_i (in), axi_wdata_o/wstrb_o/wvalid_o (out), axi_wready_i (in), axi_bresp_i[2]/bvalid_i (in), axi_bready_o (out).

Function
REQ-005 The FSM SHALL have exactly five states: IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP; at most one AXI transaction SHALL be outstanding.
REQ-006 In IDLE with cke_i=1, curr_turn_i=01 and instr_req_i=1, the block SHALL latch instr_addr_i, set src=instr and go to RD_ADDR.
REQ-007 In IDLE with cke_i=1, curr_turn_i=10 and data_req_i=1, the block SHALL latch addr, wdata, be and we, set src=data, and go to WR_REQ if we=1, else to RD_ADDR.
REQ-008 In IDLE with curr_turn_i equal to 00 or 11, or with cke_i=0, the block SHALL start no transaction.
REQ-009 In RD_ADDR the block SHALL drive axi_arvalid_o=1 with the latched address, and on arvalid&arready SHALL go to RD_RESP.
REQ-010 In RD_RESP the block SHALL drive axi_rready_o=1, and on rvalid&rready SHALL register rdata and the error bit (rresp[1]) into the src port's rdata/err, pulse that port's rvalid_o for exactly 1 cycle on the next cycle, and return to IDLE.
REQ-011 In WR_REQ the block SHALL assert awvalid and wvalid and track the AW and W handshakes independently with aw_done/w_done flags; each valid SHALL drop after its own handshake; the block SHALL go to WR_RESP once both handshakes are done, including when both complete in the same cycle.
REQ-012 In WR_RESP the block SHALL drive axi_bready_o=1, and on bvalid&bready SHALL pulse data_rvalid_o for 1 cycle next cycle, with data_err_o=bresp[1] and data_rdata_o unchanged, then return to IDLE.
REQ-013 gnt_o SHALL be combinational: instr_gnt_o = arvalid&arready&(src==instr); data_gnt_o is asserted in the cycle of the AR handshake (read) or of the last of the AW/W handshakes (write), with src==data; each gnt SHALL be high for exactly 1 cycle per transaction.
REQ-014 Once the block leaves IDLE, changes on curr_turn_i, the *_req_i inputs and cke_i SHALL NOT affect the in-flight transaction; AXI valid signals SHALL NOT deassert before their handshake.
REQ-015 With zero-wait AXI, a read SHALL take: issue in cycle N, gnt in N+1, R handshake in N+2, rvalid in N+3; the next transaction SHALL be issuable from IDLE in N+3.
REQ-016 The block SHALL drive axi_wstrb_o = latched be and axi_awaddr_o = axi_araddr_o = latched addr; the AXI address is passed through unaligned, with no modification.

Reset
REQ-017 While arst_i=1, asynchronously, the state SHALL be IDLE, and every valid, ready, gnt, rvalid and err output and every done flag SHALL be 0, with all latched address/data registers at 0.
REQ-018 Reset asserted mid-transaction SHALL abandon that transaction with no response pulse; after release the block SHALL be in IDLE.

Verification
REQ-019 Instruction read: turn=01, instr_req=1, addr=0x100, arready=1, rdata=0xDEADBEEF with rresp=00 -> instr_gnt is 1 cycle; instr_rvalid is 1 cycle with rdata=0xDEADBEEF and err=0; data_* outputs stay 0.
REQ-020 Data write: turn=10, we=1, be=0x3, addr=0x2000, wdata=0x1234; wready arrives 2 cycles after awready; bresp=10 -> awaddr=0x2000 and wstrb=0x3; data_gnt is 1 cycle, after wready; data_rvalid=1 with data_err=1.
REQ-021 Same-cycle AW/W: awready=wready=1 on the first cycle -> gnt in that cycle and direct entry to WR_RESP.
REQ-022 Turn gating: curr_turn=11 with both reqs high for 10 cycles -> no arvalid/awvalid; then turn=10 -> a data transaction starts the next cycle.
REQ-023 Mid-flight: during RD_RESP with arvalid stable until handshake, toggle curr_turn and assert arst_i -> every output is 0 immediately and no rvalid pulse follows.
REQ-024 Back-pressure: arready held low for 5 cycles -> arvalid and araddr are stable throughout, and gnt appears only on the handshake cycle.
